// File: rtl/ahb3lite_interconnect_master_port.sv
// Master-side port of the AHB3-Lite multi-layer switch.
// Decodes the master's address phase against a per-slave base/mask map, forwards
// it to the addressed slave port, holds it while that slave port has not granted
// this master, muxes the data-phase response back, and answers unmapped accesses
// with a two-cycle ERROR.
module ahb3lite_interconnect_master_port #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int SLAVES     = 8
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,

    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,

    input  logic [HADDR_SIZE-1:0] slvHADDRbase [SLAVES],
    input  logic [HADDR_SIZE-1:0] slvHADDRmask [SLAVES],

    output logic [SLAVES-1:0]     slvHSEL,
    output logic [HADDR_SIZE-1:0] slvHADDR,
    output logic [HDATA_SIZE-1:0] slvHWDATA,
    output logic                  slvHWRITE,
    output logic [2:0]            slvHSIZE,
    output logic [2:0]            slvHBURST,
    output logic [3:0]            slvHPROT,
    output logic [1:0]            slvHTRANS,
    output logic                  slvHMASTLOCK,
    output logic                  slvHREADY,
    input  logic [HDATA_SIZE-1:0] slvHRDATA [SLAVES],
    input  logic [SLAVES-1:0]     slvHREADYOUT,
    input  logic [SLAVES-1:0]     slvHRESP,

    output logic [SLAVES-1:0]     can_switch,
    input  logic [SLAVES-1:0]     granted
);

    localparam int SLAVE_BITS = (SLAVES == 1) ? 1 : $clog2(SLAVES);

    localparam logic [2:0] NO_ACCESS  = 3'd0;
    localparam logic [2:0] ACCESS     = 3'd1;
    localparam logic [2:0] WAIT_GRANT = 3'd2;
    localparam logic [2:0] ERR1       = 3'd3;
    localparam logic [2:0] ERR2       = 3'd4;

    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    logic [2:0]            state_q, state_d;
    logic [SLAVE_BITS-1:0] dp_q, dp_d;
    logic                  dp_vld_q, dp_vld_d;
    logic [SLAVE_BITS-1:0] lat_slv_q, lat_slv_d;
    logic                  lat_load;

    logic [HADDR_SIZE-1:0] lat_addr_q;
    logic                  lat_write_q;
    logic [2:0]            lat_size_q;
    logic [2:0]            lat_burst_q;
    logic [3:0]            lat_prot_q;
    logic                  lat_lock_q;

    logic                  hit;
    logic [SLAVE_BITS-1:0] hit_idx;
    logic                  accept;

    // Address decode: scan from the top so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if (HSEL && ((HADDR & slvHADDRmask[s]) == (slvHADDRbase[s] & slvHADDRmask[s]))) begin
                hit     = 1'b1;
                hit_idx = SLAVE_BITS'(s);
            end
        end
    end

    assign accept = HSEL & HREADY & HTRANS[1];

    // Next-state logic: transfer routing, grant wait and the two-cycle error
    always_comb begin
        state_d   = state_q;
        dp_d      = dp_q;
        dp_vld_d  = dp_vld_q;
        lat_slv_d = lat_slv_q;
        lat_load  = 1'b0;
        case (state_q)
            WAIT_GRANT: begin
                if (granted[lat_slv_q] && slvHREADYOUT[lat_slv_q]) begin
                    state_d  = ACCESS;
                    dp_d     = lat_slv_q;
                    dp_vld_d = 1'b1;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                // NO_ACCESS, ACCESS and ERR2 all decode a fresh address phase
                if (HREADY) begin
                    if (accept) begin
                        if (!hit) begin
                            state_d  = ERR1;
                            dp_vld_d = 1'b0;
                        end else if (granted[hit_idx]) begin
                            state_d  = ACCESS;
                            dp_d     = hit_idx;
                            dp_vld_d = 1'b1;
                        end else begin
                            state_d   = WAIT_GRANT;
                            dp_vld_d  = 1'b0;
                            lat_slv_d = hit_idx;
                            lat_load  = 1'b1;
                        end
                    end else begin
                        state_d  = HSEL ? ACCESS : NO_ACCESS;
                        dp_vld_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // Control registers: FSM state, data-phase slave and the held slave index
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= NO_ACCESS;
            dp_q      <= '0;
            dp_vld_q  <= 1'b0;
            lat_slv_q <= '0;
        end else begin
            state_q   <= state_d;
            dp_q      <= dp_d;
            dp_vld_q  <= dp_vld_d;
            lat_slv_q <= lat_slv_d;
        end
    end

    // Held address-phase fields for a transfer still waiting on its grant
    always_ff @(posedge HCLK) begin
        if (lat_load) begin
            lat_addr_q  <= HADDR;
            lat_write_q <= HWRITE;
            lat_size_q  <= HSIZE;
            lat_burst_q <= HBURST;
            lat_prot_q  <= HPROT;
            lat_lock_q  <= HMASTLOCK;
        end
    end

    // Slave-side address phase: held copy while waiting, live master otherwise
    always_comb begin
        slvHSEL      = '0;
        slvHADDR     = HADDR;
        slvHWRITE    = HWRITE;
        slvHSIZE     = HSIZE;
        slvHBURST    = HBURST;
        slvHPROT     = HPROT;
        slvHTRANS    = HTRANS;
        slvHMASTLOCK = HMASTLOCK;
        if (state_q == WAIT_GRANT) begin
            slvHSEL[lat_slv_q] = 1'b1;
            slvHADDR           = lat_addr_q;
            slvHWRITE          = lat_write_q;
            slvHSIZE           = lat_size_q;
            slvHBURST          = lat_burst_q;
            slvHPROT           = lat_prot_q;
            slvHTRANS          = HTRANS_NONSEQ;
            slvHMASTLOCK       = lat_lock_q;
        end else if (hit) begin
            slvHSEL[hit_idx] = 1'b1;
        end
        // Requests drop immediately while reset is held, not at the next edge
        if (!HRESETn) begin
            slvHSEL = '0;
        end
    end

    // Master-side response: stall, error or the data-phase slave's answer
    always_comb begin
        HRDATA    = slvHRDATA[dp_q];
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            WAIT_GRANT: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b0;
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: begin
                if (dp_vld_q) begin
                    HREADYOUT = slvHREADYOUT[dp_q];
                    HRESP     = slvHRESP[dp_q];
                end
            end
        endcase
    end

    assign slvHWDATA = HWDATA;
    assign slvHREADY = HREADYOUT;

    // Arbitration hints: never release mid-burst, while locked, or while waiting on that slave
    always_comb begin
        can_switch = '0;
        for (int s = 0; s < SLAVES; s++) begin
            can_switch[s] = ~HMASTLOCK
                          & ~((HTRANS == HTRANS_SEQ) | (HTRANS == HTRANS_BUSY))
                          & ~((state_q == WAIT_GRANT) & (lat_slv_q == SLAVE_BITS'(s)));
        end
    end

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Testbench for ahb3lite_interconnect_master_port: directed scenarios with literal
// expectations plus randomized traffic compared cycle-by-cycle against a
// transaction-level reference model.
module tb_ahb3lite_interconnect_master_port;

    logic        HRESETn;
    logic        HCLK;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] base [4];
    logic [31:0] mask [4];
    logic [3:0]  slvHSEL;
    logic [31:0] slvHADDR;
    logic [31:0] slvHWDATA;
    logic        slvHWRITE;
    logic [2:0]  slvHSIZE;
    logic [2:0]  slvHBURST;
    logic [3:0]  slvHPROT;
    logic [1:0]  slvHTRANS;
    logic        slvHMASTLOCK;
    logic        slvHREADY;
    logic [31:0] srdata [4];
    logic [3:0]  slvHREADYOUT;
    logic [3:0]  slvHRESP;
    logic [3:0]  can_switch;
    logic [3:0]  granted;

    int checks   = 0;
    int failures = 0;

    ahb3lite_interconnect_master_port #(
        .HADDR_SIZE(32),
        .HDATA_SIZE(32),
        .SLAVES    (4)
    ) dut (
        .HRESETn     (HRESETn),
        .HCLK        (HCLK),
        .HSEL        (HSEL),
        .HADDR       (HADDR),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HPROT       (HPROT),
        .HTRANS      (HTRANS),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .HREADYOUT   (HREADYOUT),
        .HRESP       (HRESP),
        .slvHADDRbase(base),
        .slvHADDRmask(mask),
        .slvHSEL     (slvHSEL),
        .slvHADDR    (slvHADDR),
        .slvHWDATA   (slvHWDATA),
        .slvHWRITE   (slvHWRITE),
        .slvHSIZE    (slvHSIZE),
        .slvHBURST   (slvHBURST),
        .slvHPROT    (slvHPROT),
        .slvHTRANS   (slvHTRANS),
        .slvHMASTLOCK(slvHMASTLOCK),
        .slvHREADY   (slvHREADY),
        .slvHRDATA   (srdata),
        .slvHREADYOUT(slvHREADYOUT),
        .slvHRESP    (slvHRESP),
        .can_switch  (can_switch),
        .granted     (granted)
    );

    // Single-master bus: the master sees this port's own HREADYOUT
    assign HREADY = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    // ---------------- reference model ----------------
    localparam int M_NO   = 0;
    localparam int M_ACC  = 1;
    localparam int M_WAIT = 2;
    localparam int M_E1   = 3;
    localparam int M_E2   = 4;

    int          m_mode = M_NO;
    int          m_dp   = -1;
    logic [31:0] l_addr;
    logic        l_write;
    logic [2:0]  l_size;
    logic [2:0]  l_burst;
    logic [3:0]  l_prot;
    logic        l_lock;
    int          l_slave = 0;

    logic        s_rst, s_hsel, s_hready, s_hwrite, s_hlock;
    logic [31:0] s_haddr;
    logic [1:0]  s_htrans;
    logic [2:0]  s_hsize, s_hburst;
    logic [3:0]  s_hprot, s_granted, s_rdy;

    function automatic int decode(input logic sel, input logic [31:0] a);
        if (!sel) return -1;
        for (int s = 0; s < 4; s++)
            if ((a & mask[s]) == (base[s] & mask[s])) return s;
        return -1;
    endfunction

    always begin
        logic [3:0]  e_sel, e_cs;
        logic [31:0] e_addr;
        logic [1:0]  e_trans;
        logic        e_write, e_lock, e_rdy, e_resp;
        logic [2:0]  e_size, e_burst;
        logic [3:0]  e_prot;
        int          d;

        @(negedge HCLK);
        if (!HRESETn) begin
            m_mode = M_NO;
            m_dp   = -1;
        end

        e_sel = '0;
        if (m_mode == M_WAIT) begin
            e_sel[l_slave] = 1'b1;
            e_addr = l_addr; e_trans = 2'b10; e_write = l_write;
            e_size = l_size; e_burst = l_burst; e_prot = l_prot; e_lock = l_lock;
        end else begin
            d = decode(HSEL, HADDR);
            if (d >= 0) e_sel[d] = 1'b1;
            e_addr = HADDR; e_trans = HTRANS; e_write = HWRITE;
            e_size = HSIZE; e_burst = HBURST; e_prot = HPROT; e_lock = HMASTLOCK;
        end
        if (!HRESETn) e_sel = '0;

        case (m_mode)
            M_WAIT:  begin e_rdy = 1'b0; e_resp = 1'b0; end
            M_E1:    begin e_rdy = 1'b0; e_resp = 1'b1; end
            M_E2:    begin e_rdy = 1'b1; e_resp = 1'b1; end
            default: begin
                if (m_dp >= 0) begin e_rdy = slvHREADYOUT[m_dp]; e_resp = slvHRESP[m_dp]; end
                else           begin e_rdy = 1'b1;               e_resp = 1'b0;           end
            end
        endcase

        for (int s = 0; s < 4; s++)
            e_cs[s] = !HMASTLOCK && (HTRANS == 2'b00 || HTRANS == 2'b10)
                      && !(m_mode == M_WAIT && s == l_slave);

        chk("cmp_slvHSEL", slvHSEL, e_sel);
        chk("cmp_slvHADDR", slvHADDR, e_addr);
        chk("cmp_slvHTRANS", slvHTRANS, e_trans);
        chk("cmp_slvctrl", {slvHWRITE, slvHSIZE, slvHBURST, slvHPROT, slvHMASTLOCK},
            {e_write, e_size, e_burst, e_prot, e_lock});
        chk("cmp_HREADYOUT", HREADYOUT, e_rdy);
        chk("cmp_HRESP", HRESP, e_resp);
        chk("cmp_slvHREADY", slvHREADY, e_rdy);
        chk("cmp_slvHWDATA", slvHWDATA, HWDATA);
        chk("cmp_can_switch", can_switch, e_cs);
        if (HRESETn && (m_mode == M_ACC || m_mode == M_NO) && m_dp >= 0)
            chk("cmp_HRDATA", HRDATA, srdata[m_dp]);

        s_rst = HRESETn; s_hsel = HSEL; s_haddr = HADDR; s_htrans = HTRANS;
        s_hready = HREADY; s_hwrite = HWRITE; s_hsize = HSIZE; s_hburst = HBURST;
        s_hprot = HPROT; s_hlock = HMASTLOCK; s_granted = granted; s_rdy = slvHREADYOUT;

        @(posedge HCLK);
        if (!s_rst) begin
            m_mode = M_NO;
            m_dp   = -1;
        end else if (m_mode == M_WAIT) begin
            if (s_granted[l_slave] && s_rdy[l_slave]) begin
                m_mode = M_ACC;
                m_dp   = l_slave;
            end
        end else if (m_mode == M_E1) begin
            m_mode = M_E2;
        end else if (s_hready) begin
            d = decode(s_hsel, s_haddr);
            if (s_hsel && s_htrans[1]) begin
                if (d < 0) begin
                    m_mode = M_E1; m_dp = -1;
                end else if (s_granted[d]) begin
                    m_mode = M_ACC; m_dp = d;
                end else begin
                    m_mode = M_WAIT; m_dp = -1; l_slave = d;
                    l_addr = s_haddr; l_write = s_hwrite; l_size = s_hsize;
                    l_burst = s_hburst; l_prot = s_hprot; l_lock = s_hlock;
                end
            end else begin
                m_mode = s_hsel ? M_ACC : M_NO;
                m_dp   = -1;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        HRESETn = 1'b0; HSEL = 1'b1; HADDR = 32'h1000_0000; HWDATA = '0; HWRITE = 1'b0;
        HSIZE = '0; HBURST = '0; HPROT = '0; HTRANS = 2'b10; HMASTLOCK = 1'b0;
        // 0x0/0x1/0x2 map to slaves 0..2; slave 3 overlaps all of 0x0-0x3 and wins only 0x3
        base[0] = 32'h0000_0000; mask[0] = 32'hF000_0000;
        base[1] = 32'h1000_0000; mask[1] = 32'hF000_0000;
        base[2] = 32'h2000_0000; mask[2] = 32'hF000_0000;
        base[3] = 32'h3000_0000; mask[3] = 32'hC000_0000;
        for (int s = 0; s < 4; s++) srdata[s] = 32'h1111_0000 * (s + 1);
        slvHREADYOUT = 4'hF; slvHRESP = 4'h0; granted = 4'hF;

        #2;
        chk("reset_HREADYOUT", HREADYOUT, 1'b1);
        chk("reset_HRESP", HRESP, 1'b0);
        chk("reset_slvHSEL", slvHSEL, 4'b0000);
        cyc(); cyc();
        HRESETn = 1'b1; HTRANS = 2'b00; HSEL = 1'b0;
        cyc();

        // Read from slave 1 with grant already present; 0x1xxx_xxxx also hits slave 3
        granted = 4'b0010; HSEL = 1'b1; HADDR = 32'h1000_0004; HTRANS = 2'b10; HWRITE = 1'b0;
        #1 chk("rd_slvHSEL_lowest_wins", slvHSEL, 4'b0010);
        cyc();
        HTRANS = 2'b00; srdata[1] = 32'hCAFE_F00D;
        #1 chk("rd_HRDATA", HRDATA, 32'hCAFE_F00D);
        chk("rd_HRESP", HRESP, 1'b0);
        chk("rd_HREADYOUT", HREADYOUT, 1'b1);

        // Unmapped write -> two-cycle ERROR
        cyc();
        HADDR = 32'h5000_0000; HWRITE = 1'b1; HTRANS = 2'b10;
        #1 chk("err_slvHSEL0", slvHSEL, 4'b0000);
        cyc();
        #1 chk("err1_resp", {HREADYOUT, HRESP}, 2'b01);
        chk("err1_slvHSEL", slvHSEL, 4'b0000);
        cyc();
        HTRANS = 2'b00;
        #1 chk("err2_resp", {HREADYOUT, HRESP}, 2'b11);
        chk("err2_slvHSEL", slvHSEL, 4'b0000);
        cyc();
        #1 chk("after_err_okay", {HREADYOUT, HRESP}, 2'b10);

        // Write to slave 2 without its grant for three cycles
        cyc();
        granted = 4'b0001; HADDR = 32'h2000_0010; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
        #1 chk("wait_req_slvHSEL", slvHSEL, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            cyc();
            HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
            #1 chk("wait_HREADYOUT", HREADYOUT, 1'b0);
            chk("wait_slvHTRANS", slvHTRANS, 2'b10);
            chk("wait_slvHADDR", slvHADDR, 32'h2000_0010);
            chk("wait_slvHSEL", slvHSEL, 4'b0100);
            chk("wait_slvHWRITE", {slvHWRITE, slvHSIZE}, 4'b1010);
            chk("wait_can_switch", can_switch, 4'b1011);
        end
        cyc();
        granted = 4'b0100;
        #1 chk("grant_edge_HREADYOUT", HREADYOUT, 1'b0);
        cyc();
        #1 chk("granted_data_phase", {HREADYOUT, HRESP}, 2'b10);

        // can_switch under SEQ, locked NONSEQ, then unlocked IDLE
        cyc();
        granted = 4'hF; HADDR = 32'h0000_0100; HTRANS = 2'b11;
        #1 chk("cs_seq", can_switch, 4'b0000);
        cyc();
        HTRANS = 2'b10; HMASTLOCK = 1'b1;
        #1 chk("cs_locked", can_switch, 4'b0000);
        cyc();
        HTRANS = 2'b00; HMASTLOCK = 1'b0;
        #1 chk("cs_idle", can_switch, 4'b1111);

        // Reset while waiting for a grant
        cyc();
        granted = 4'b0001; HADDR = 32'h2000_0020; HTRANS = 2'b10;
        cyc();
        HTRANS = 2'b00;
        #1 chk("rstwait_stalled", HREADYOUT, 1'b0);
        #1 HRESETn = 1'b0;
        #1 chk("rstwait_HREADYOUT", HREADYOUT, 1'b1);
        chk("rstwait_slvHSEL", slvHSEL, 4'b0000);
        cyc();
        HRESETn = 1'b1;
        cyc();
        #1 chk("rstwait_idle_okay", {HREADYOUT, HRESP}, 2'b10);

        // Randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            cyc();
            HRESETn      = ($urandom_range(0, 199) != 0);
            HSEL         = ($urandom_range(0, 9) != 0);
            HADDR        = {4'($urandom_range(0, 5)), 28'($urandom)};
            HTRANS       = 2'($urandom);
            HWRITE       = 1'($urandom);
            HSIZE        = 3'($urandom);
            HBURST       = 3'($urandom);
            HPROT        = 4'($urandom);
            HMASTLOCK    = ($urandom_range(0, 5) == 0);
            HWDATA       = $urandom;
            granted      = 4'($urandom) | 4'($urandom);
            slvHREADYOUT = 4'($urandom) | 4'($urandom);
            slvHRESP     = 4'($urandom) & 4'($urandom) & 4'($urandom);
            for (int s = 0; s < 4; s++) srdata[s] = $urandom;
        end
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb3lite_interconnect_master_port.md
Name: ahb3lite_interconnect_master_port

Overview:
Master-side port of the AHB3-Lite multi-layer switch. It terminates one AHB master and acts as that master's slave. It decodes each address phase against a per-slave base/mask map and forwards the transfer to the addressed slave port. If that slave port has not granted this master, the port holds the address phase and stalls the master until the grant arrives. It returns HRDATA/HREADY/HRESP from the slave being served in the data phase, drives the can_switch hints used by slave-port arbitration, and answers unmapped accesses with a two-cycle ERROR.

Parameters:
HADDR_SIZE, 32, address bus width
HDATA_SIZE, 32, data bus width
SLAVES, 8, number of slave ports
SLAVE_BITS, SLAVES==1 ? 1 : $clog2(SLAVES), localparam, slave index width

Ports:
HRESETn  in  1  asynchronous active-low reset
HCLK  in  1  clock, rising edge
HSEL  in  1  master select
HADDR  in  HADDR_SIZE  master address
HWDATA  in  HDATA_SIZE  master write data
HRDATA  out  HDATA_SIZE  read data to master
HWRITE  in  1  write
HSIZE  in  3  size
HBURST  in  3  burst
HPROT  in  4  protection
HTRANS  in  2  transfer type
HMASTLOCK  in  1  locked transfer
HREADY  in  1  master-bus HREADY
HREADYOUT  out  1  ready to master bus
HRESP  out  1  response to master
slvHADDRbase  in  SLAVES x HADDR_SIZE  slave base addresses
slvHADDRmask  in  SLAVES x HADDR_SIZE  slave address masks
slvHSEL  out  SLAVES  per-slave request
slvHADDR  out  HADDR_SIZE  shared address to slave ports
slvHWDATA  out  HDATA_SIZE  shared write data
slvHWRITE, slvHSIZE, slvHBURST, slvHPROT, slvHTRANS, slvHMASTLOCK  out  1/3/3/4/2/1  shared control
slvHREADY  out  1  HREADY forwarded to slave ports
slvHRDATA  in  SLAVES x HDATA_SIZE  read data per slave port
slvHREADYOUT  in  SLAVES  ready per slave port
slvHRESP  in  SLAVES  response per slave port
can_switch  out  SLAVES  slave port may re-arbitrate away from this master
granted  in  SLAVES  slave port s currently grants this master

Behaviour:
- Clock and reset: single clock HCLK; reset HRESETn is asynchronous, active-low.
- Reset values: state NO_ACCESS, HREADYOUT=1, HRESP=OKAY(0), slvHSEL=0, pending=0, data-phase slave invalid.
- Decode (combinational):
  - match[s] = HSEL & ((HADDR & mask[s]) == (base[s] & mask[s])).
  - Multiple matches: lowest index wins.
  - Address phase accepted when HREADY & HTRANS[1] (NONSEQ/SEQ).
- States:
  - NO_ACCESS/ACCESS: pass-through. slvHSEL[s] = match[s] (the winning s). Shared outputs come from the live master signals.
  - Accepted, no match -> ERR1.
  - Accepted, match s, granted[s]=1 -> data-phase slave dp=s, stay ACCESS.
  - Accepted, match s, granted[s]=0 -> latch HADDR/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK and s; go to WAIT_GRANT.
  - WAIT_GRANT:
    - Slave outputs come from the latch; slvHSEL[s_latched]=1; slvHTRANS forced to NONSEQ.
    - HREADYOUT=0, HRESP=OKAY.
    - Exit when granted[s] & slvHREADYOUT[s]: dp=s, next state ACCESS, latch released.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1 -> ACCESS/NO_ACCESS per the new address phase.
  - An address phase arriving in ERR2 is decoded normally.
- Data-phase mux (ACCESS):
  - HRDATA, HREADYOUT, HRESP come from slave dp.
  - No valid dp (idle/busy): HREADYOUT=1, HRESP=0.
  - dp updates only when HREADY=1.
- slvHWDATA = HWDATA (the master already presents data-phase data). slvHREADY = HREADYOUT.
- can_switch[s] = ~HMASTLOCK & ~(HTRANS==SEQ | HTRANS==BUSY) & ~(state==WAIT_GRANT & s==s_latched). All other bits follow the same rule.
- IDLE/BUSY transfers: never cause a wait; zero-wait OKAY.
- Reset mid-WAIT_GRANT: immediate return to reset values; latched transfer discarded.
- granted[s] already 1 at acceptance: no stall cycle inserted (0 extra latency).

Test Plan:
- SLAVES=4, base[1]=0x1000_0000, mask=0xF000_0000, granted=4'b0010: NONSEQ read 0x1000_0004 -> slvHSEL=4'b0010 in the same cycle. Next cycle slvHRDATA[1]=0xCAFE_F00D with HREADYOUT[1]=1 -> HRDATA=0xCAFE_F00D, HRESP=0.
- NONSEQ write 0x5000_0000 (no match) -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1, slvHSEL=0 throughout.
- Access to slave 2 with granted[2]=0 for 3 cycles, then 1 -> HREADYOUT=0 for 3 cycles, slvHTRANS=NONSEQ, slvHADDR held at the latched value. Data phase proceeds after the grant.
- SEQ beat, then HMASTLOCK=1 NONSEQ -> can_switch=0 in both. IDLE with HMASTLOCK=0 -> can_switch=all ones.
- Assert HRESETn=0 in WAIT_GRANT -> HREADYOUT=1, slvHSEL=0 asynchronously. After release, IDLE gives OKAY.
- Addresses matching slaves 1 and 3 simultaneously -> slvHSEL=4'b0010.
